text_box_overlay: RTL and testbench
===================================

TEXT_BOX_OVERLAY -- requirements
Module: text_box_overlay

Interface
REQ-001 SHALL have parameter X_LOC, default 11'd30: left edge of the box in visible pixels.
REQ-002 SHALL have parameter Y_LOC, default 11'd450: top edge of the box in visible lines.
REQ-003 SHALL have parameter PIXEL_SCALE, default 7, legal range 1..7: screen pixels per glyph pixel in each axis (S).
REQ-004 SHALL have parameter CHARS_PER_LINE, default 5, legal range 1..64 (CPL).
REQ-005 SHALL have parameter NUM_LINES, default 2, legal range 1..64 (NL); ADDR_W = $clog2(CPL*NL), minimum 1.
REQ-006 Port: clk  in  1  system clock, single clock domain.
REQ-007 Port: rst  in  1  asynchronous, active-low reset.
REQ-008 Ports: hc_visible in 11 and vc_visible in 11: current beam position.
REQ-009 Ports: wr_valid in 1; wr_ready out 1; wr_addr in ADDR_W (row*CPL+col); wr_data in 8 (character code).
REQ-010 Ports: clear_req in 1 (fill buffer with spaces); busy out 1 (clear sweep in progress).
REQ-011 Ports: in_square out 1; in_character out 1; both registered.

Function
REQ-012 Box geometry SHALL be W = 6*S*CPL + S and H = 8*S*NL + S; box_hit = X_LOC <= hc < X_LOC+W and Y_LOC <= vc < Y_LOC+H.
REQ-013 Coordinates SHALL be rx = hc-X_LOC-S and ry = vc-Y_LOC-S; text_hit requires box_hit, hc >= X_LOC+S and vc >= Y_LOC+S.
REQ-014 Cell mapping SHALL be col = rx/(6S), gx = (rx%(6S))/S, row = ry/(8S), gy = (ry%(8S))/S.
REQ-015 in_character SHALL be 1 only when text_hit, gx != 5 (spacer column) and glyph(code[row][col], gx, gy) = 1.
REQ-016 in_square and in_character SHALL each have a fixed latency of exactly 2 clk cycles from hc_visible/vc_visible; the intermediate stage is the buffer read.
REQ-017 Character buffer SHALL hold CPL*NL 8-bit codes with one synchronous write port and one synchronous read port.
REQ-018 A write SHALL occur on a cycle with wr_valid && wr_ready; the new code SHALL be visible to a pixel read issued on the following cycle or later.
REQ-019 A write with wr_addr >= CPL*NL SHALL be accepted and dropped with no buffer change.
REQ-020 FSM states SHALL be IDLE and CLEAR; wr_ready = (state == IDLE); busy = (state == CLEAR).
REQ-021 In IDLE, clear_req = 1 SHALL move the FSM to CLEAR on the next cycle; a simultaneous write in that cycle SHALL still be accepted.
REQ-022 In CLEAR, the FSM SHALL write 8'd32 to address 0..CPL*NL-1, one per cycle, then return to IDLE; busy SHALL be high for exactly CPL*NL cycles.
REQ-023 clear_req asserted during CLEAR SHALL be ignored.
REQ-024 Pixel reads SHALL continue during CLEAR and return whatever the buffer holds.

Reset
REQ-025 While rst = 0: in_square = 0, in_character = 0, pipeline registers = 0, state = CLEAR with sweep address 0, busy = 1, wr_ready = 0.
REQ-026 On reset release, a full clear sweep SHALL run; reset asserted mid-sweep SHALL restart the sweep from address 0.

Configuration
REQ-027 Macro TEXT_CURSOR_EN defined: add input cursor_addr [ADDR_W-1:0] and a 5-bit frame counter that increments on each cycle with hc_visible == 0 && vc_visible == 0.
REQ-028 With TEXT_CURSOR_EN defined, when frame counter bit 4 = 1, the text_hit pixels of cell cursor_addr (spacer column included) SHALL output inverted in_character; cursor_addr >= CPL*NL shows no cursor.
REQ-029 Macro TEXT_CURSOR_EN undefined: the cursor_addr port, the frame counter and the inversion logic SHALL be absent.

Structure
REQ-030 Package text_box_pkg SHALL hold CHAR_W = 5, CHAR_H = 8, CHAR_PITCH = 6, SPACE_CODE = 8'd32 and the FSM state enum.
REQ-031 The buffer SHALL be the sub-module text_char_ram; glyph lookup SHALL instantiate the existing characters module (select, x, y -> pix).

Verification (default parameters: box x 30..246, y 450..568, buffer 10 cells)
REQ-032 Reset release -> busy = 1 for exactly 10 cycles, wr_ready = 0 throughout; afterwards all cells read 32.
REQ-033 Write 65 to address 0, then scan hc 37..78, vc 457..512 -> in_character matches the glyph for 65 pixel-replicated 7x7, and is 0 for hc 72..78, each sample 2 cycles late.
REQ-034 Beam at hc 29, 30, 246, 247 on vc 460 -> in_square 0, 1, 1, 0; hc 30..36 -> in_character 0 (border).
REQ-035 Write 66 to wr_addr 10 -> accepted, no cell changes, display unchanged.
REQ-036 With cells loaded, clear_req pulsed mid-frame, plus a second clear_req 3 cycles later -> single 10-cycle sweep, writes stalled, all cells 32 afterwards.
REQ-037 TEXT_CURSOR_EN, cursor_addr 6, 16 frames elapsed -> cell row 1, col 1 inverted; 16 more frames -> normal.

Source files
------------

// File: rtl/text_box_pkg.sv
// text_box_pkg: glyph geometry constants and clear-sequencer state type shared by the
// text box overlay and its glyph/buffer sub-modules.
package text_box_pkg;

    localparam int         CHAR_W     = 5;
    localparam int         CHAR_H     = 8;
    localparam int         CHAR_PITCH = 6;
    localparam logic [7:0] SPACE_CODE = 8'd32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/characters.sv
// characters: combinational 5x8 glyph ROM; pix is the glyph bit at column x, row y.
// Codes without a glyph, and columns beyond the glyph width, render blank.
module characters
    import text_box_pkg::*;
(
    input  logic [7:0] select,
    input  logic [2:0] x,
    input  logic [2:0] y,
    output logic       pix
);

    logic [39:0] w_bits;
    logic [5:0]  w_sh;
    logic [4:0]  w_row;

    // Row 0 sits in bits [39:35]; bit 4 of each row is the leftmost column.
    always_comb begin
        case (select)
            8'h30:   w_bits = 40'b01110_10001_10011_10101_11001_10001_01110_00000;
            8'h31:   w_bits = 40'b00100_01100_00100_00100_00100_00100_01110_00000;
            8'h32:   w_bits = 40'b01110_10001_00001_00010_00100_01000_11111_00000;
            8'h33:   w_bits = 40'b11111_00010_00100_00010_00001_10001_01110_00000;
            8'h34:   w_bits = 40'b00010_00110_01010_10010_11111_00010_00010_00000;
            8'h35:   w_bits = 40'b11111_10000_11110_00001_00001_10001_01110_00000;
            8'h36:   w_bits = 40'b00110_01000_10000_11110_10001_10001_01110_00000;
            8'h37:   w_bits = 40'b11111_00001_00010_00100_01000_01000_01000_00000;
            8'h38:   w_bits = 40'b01110_10001_10001_01110_10001_10001_01110_00000;
            8'h39:   w_bits = 40'b01110_10001_10001_01111_00001_00010_01100_00000;
            8'h41:   w_bits = 40'b01110_10001_10001_11111_10001_10001_10001_00000;
            8'h42:   w_bits = 40'b11110_10001_10001_11110_10001_10001_11110_00000;
            8'h43:   w_bits = 40'b01110_10001_10000_10000_10000_10001_01110_00000;
            8'h44:   w_bits = 40'b11100_10010_10001_10001_10001_10010_11100_00000;
            8'h45:   w_bits = 40'b11111_10000_10000_11110_10000_10000_11111_00000;
            8'h46:   w_bits = 40'b11111_10000_10000_11110_10000_10000_10000_00000;
            default: w_bits = '0;
        endcase
        w_sh  = {3'b000, ~y} * 6'd5;
        w_row = w_bits[w_sh +: 5];
        pix   = (x < 3'(CHAR_W)) ? w_row[3'd4 - x] : 1'b0;
    end

endmodule

// File: rtl/text_char_ram.sv
// text_char_ram: character code buffer, one synchronous write port and one synchronous
// read port; a read in the cycle after a write returns the new code.
module text_char_ram #(
    parameter int DEPTH = 10,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Only the output register is reset; array contents are owned by the clear sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= 8'd0;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/text_box_overlay.sv
// text_box_overlay: bordered character box over the visible raster with a clearable buffer.
// Define TEXT_CURSOR_EN to add a blinking inverted cursor cell (cursor_addr input).
module text_box_overlay
    import text_box_pkg::*;
#(
    parameter logic [10:0] X_LOC          = 11'd30,
    parameter logic [10:0] Y_LOC          = 11'd450,
    parameter int          PIXEL_SCALE    = 7,
    parameter int          CHARS_PER_LINE = 5,
    parameter int          NUM_LINES      = 2,
    localparam int         CELLS          = CHARS_PER_LINE * NUM_LINES,
    localparam int         ADDR_W         = (CELLS > 1) ? $clog2(CELLS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [10:0]       hc_visible,
    input  logic [10:0]       vc_visible,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              clear_req,
    output logic              busy,
`ifdef TEXT_CURSOR_EN
    input  logic [ADDR_W-1:0] cursor_addr,
`endif
    output logic              in_square,
    output logic              in_character
);

    localparam int S      = PIXEL_SCALE;
    localparam int CELL_W = CHAR_PITCH * S;
    localparam int CELL_H = CHAR_H * S;
    localparam int BOX_W  = CELL_W * CHARS_PER_LINE + S;
    localparam int BOX_H  = CELL_H * NUM_LINES + S;
    localparam int XL     = int'(X_LOC);
    localparam int YL     = int'(Y_LOC);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W:0]   CELLS_W   = (ADDR_W + 1)'(CELLS);

    // Clear sequencer
    clr_state_t        r_state;
    logic [ADDR_W-1:0] r_clr_addr;
    logic              r_busy;
    logic              r_wr_ready;

    logic              w_wr_keep;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_waddr;
    logic [7:0]        w_ram_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
            r_busy     <= 1'b1;
            r_wr_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clear_req) begin
                        r_state    <= ST_CLEAR;
                        r_clr_addr <= '0;
                        r_busy     <= 1'b1;
                        r_wr_ready <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (r_clr_addr == LAST_ADDR) begin
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                        r_wr_ready <= 1'b1;
                    end else begin
                        r_clr_addr <= r_clr_addr + ADDR_W'(1);
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_busy     <= 1'b0;
                    r_wr_ready <= 1'b1;
                end
            endcase
        end
    end

    assign wr_ready = r_wr_ready;
    assign busy     = r_busy;

    // Out-of-range writes complete the handshake but never reach the array.
    assign w_wr_keep   = wr_valid && r_wr_ready && ({1'b0, wr_addr} < CELLS_W);
    assign w_ram_we    = (r_state == ST_CLEAR) || w_wr_keep;
    assign w_ram_waddr = (r_state == ST_CLEAR) ? r_clr_addr : wr_addr;
    assign w_ram_wdata = (r_state == ST_CLEAR) ? SPACE_CODE : wr_data;

    // Beam position to box / cell / glyph coordinates
    int                w_hc;
    int                w_vc;
    int                w_rx;
    int                w_ry;
    int                w_col;
    int                w_row;
    int                w_gx_i;
    int                w_gy_i;
    logic              w_box_hit;
    logic              w_text_hit;
    logic [2:0]        w_gx;
    logic [2:0]        w_gy;
    logic [ADDR_W-1:0] w_raddr;

    always_comb begin
        w_hc       = int'(hc_visible);
        w_vc       = int'(vc_visible);
        w_box_hit  = (w_hc >= XL) && (w_hc < XL + BOX_W) &&
                     (w_vc >= YL) && (w_vc < YL + BOX_H);
        w_text_hit = w_box_hit && (w_hc >= XL + S) && (w_vc >= YL + S);
        w_rx       = w_text_hit ? (w_hc - XL - S) : 0;
        w_ry       = w_text_hit ? (w_vc - YL - S) : 0;
        w_col      = w_rx / CELL_W;
        w_gx_i     = (w_rx % CELL_W) / S;
        w_row      = w_ry / CELL_H;
        w_gy_i     = (w_ry % CELL_H) / S;
        w_gx       = 3'(w_gx_i);
        w_gy       = 3'(w_gy_i);
        w_raddr    = ADDR_W'(w_row * CHARS_PER_LINE + w_col);
    end

    logic [7:0] w_rd_code;

    text_char_ram #(
        .DEPTH (CELLS),
        .AW    (ADDR_W)
    ) u_char_ram (
        .clk     (clk),
        .rst_n   (rst),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rd_code)
    );

    // Stage 1: position flags and glyph coordinates aligned with the buffer read
    logic       r_box_d1;
    logic       r_text_d1;
    logic [2:0] r_gx_d1;
    logic [2:0] r_gy_d1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_box_d1  <= 1'b0;
            r_text_d1 <= 1'b0;
            r_gx_d1   <= 3'd0;
            r_gy_d1   <= 3'd0;
        end else begin
            r_box_d1  <= w_box_hit;
            r_text_d1 <= w_text_hit;
            r_gx_d1   <= w_gx;
            r_gy_d1   <= w_gy;
        end
    end

`ifdef TEXT_CURSOR_EN
    logic [4:0] r_frame;
    logic       r_cur_d1;
    logic       w_cur_hit;

    assign w_cur_hit = w_text_hit && (w_raddr == cursor_addr) &&
                       ({1'b0, cursor_addr} < CELLS_W);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame  <= 5'd0;
            r_cur_d1 <= 1'b0;
        end else begin
            if ((hc_visible == 11'd0) && (vc_visible == 11'd0)) begin
                r_frame <= r_frame + 5'd1;
            end
            r_cur_d1 <= w_cur_hit;
        end
    end
`endif

    logic w_glyph_pix;
    logic w_char_on;

    characters u_characters (
        .select (w_rd_code),
        .x      (r_gx_d1),
        .y      (r_gy_d1),
        .pix    (w_glyph_pix)
    );

    always_comb begin
        w_char_on = r_text_d1 && (r_gx_d1 != 3'(CHAR_W)) && w_glyph_pix;
`ifdef TEXT_CURSOR_EN
        // Cursor inverts the whole cell, spacer column included, during the blink-on half.
        w_char_on = w_char_on ^ (r_cur_d1 && r_frame[4]);
`endif
    end

    // Stage 2: registered outputs
    logic r_in_square;
    logic r_in_character;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_square    <= 1'b0;
            r_in_character <= 1'b0;
        end else begin
            r_in_square    <= r_box_d1;
            r_in_character <= w_char_on;
        end
    end

    assign in_square    = r_in_square;
    assign in_character = r_in_character;

endmodule

// File: tb/tb_text_box_overlay.sv
// Scoreboard bench for text_box_overlay at default parameters (box x 30..246, y 450..568,
// 10 cells); define TEXT_CURSOR_EN to also exercise the blinking cursor.
`timescale 1ns/1ps
module tb_text_box_overlay;

    localparam int CELLS = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] hc_visible = 11'd40;
    logic [10:0] vc_visible = 11'd460;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [3:0]  wr_addr = 4'd0;
    logic [7:0]  wr_data = 8'd0;
    logic        clear_req = 1'b0;
    logic        busy;
    logic        in_square;
    logic        in_character;
`ifdef TEXT_CURSOR_EN
    logic [3:0]  cursor_addr = 4'd6;
`endif

    always #5 clk = ~clk;

    text_box_overlay dut (
        .clk          (clk),
        .rst          (rst),
        .hc_visible   (hc_visible),
        .vc_visible   (vc_visible),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .clear_req    (clear_req),
        .busy         (busy),
`ifdef TEXT_CURSOR_EN
        .cursor_addr  (cursor_addr),
`endif
        .in_square    (in_square),
        .in_character (in_character)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] cells [CELLS];
    int         frame_cnt  = 0;
    int         cursor_idx = 6;

    typedef struct {
        logic sq;
        logic ch;
        int   hc;
        int   vc;
    } exp_t;

    exp_t       sb_q [$];
    logic       issue = 1'b0;
    logic [1:0] vpipe = 2'b00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    // Hand-entered glyph rows for the codes the bench uses; every other code is blank.
    function automatic logic tb_glyph(input logic [7:0] code, input int gx, input int gy);
        logic [4:0] row;
        row = 5'b00000;
        if (code == 8'd65) begin
            case (gy)
                0:       row = 5'b01110;
                3:       row = 5'b11111;
                1, 2, 4, 5, 6: row = 5'b10001;
                default: row = 5'b00000;
            endcase
        end else if (code == 8'd66) begin
            case (gy)
                0, 3, 6:    row = 5'b11110;
                1, 2, 4, 5: row = 5'b10001;
                default:    row = 5'b00000;
            endcase
        end
        return row[4 - gx];
    endfunction

    function automatic logic [1:0] exp_pix(input int h, input int v);
        logic sq, th, ch;
        int   col, row, gx, gy, idx;
        sq = (h >= 30) && (h <= 246) && (v >= 450) && (v <= 568);
        th = sq && (h >= 37) && (v >= 457);
        ch = 1'b0;
        if (th) begin
            col = (h - 37) / 42;
            gx  = ((h - 37) % 42) / 7;
            row = (v - 457) / 56;
            gy  = ((v - 457) % 56) / 7;
            idx = row * 5 + col;
            ch  = (gx != 5) && tb_glyph(cells[idx], gx, gy);
`ifdef TEXT_CURSOR_EN
            if (((frame_cnt >> 4) & 1) == 1 && idx == cursor_idx) ch = ~ch;
`endif
        end
        return {sq, ch};
    endfunction

    // Monitor: each issued beam position yields an output two edges later.
    always @(posedge clk) vpipe <= {vpipe[0], issue};

    always @(negedge clk) begin : monitor
        exp_t e;
        if (vpipe[1]) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_underflow: actual 0 entries required 1");
            end else begin
                e = sb_q.pop_front();
                if (in_square !== e.sq || in_character !== e.ch) begin
                    n_fail++;
                    $display("FAIL pixel hc=%0d vc=%0d: actual sq=%b ch=%b required sq=%b ch=%b",
                             e.hc, e.vc, in_square, in_character, e.sq, e.ch);
                end
            end
        end
    end

    task automatic pix(input int h, input int v);
        exp_t e;
        hc_visible = 11'(h);
        vc_visible = 11'(v);
        e.hc = h;
        e.vc = v;
        {e.sq, e.ch} = exp_pix(h, v);
        sb_q.push_back(e);
        issue = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        issue = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int a, input logic [7:0] d, input logic exp_ready);
        wr_valid = 1'b1;
        wr_addr  = 4'(a);
        wr_data  = d;
        check("wr_ready_on_write", {31'd0, wr_ready}, {31'd0, exp_ready});
        @(negedge clk);
        if (exp_ready && a < CELLS) cells[a] = d;
        wr_valid = 1'b0;
    endtask

    task automatic scan_cell(input int idx);
        int col, row;
        col = idx % 5;
        row = idx / 5;
        for (int gy = 0; gy < 8; gy++)
            for (int gx = 0; gx < 6; gx++)
                pix(37 + col * 42 + gx * 7 + 3, 457 + row * 56 + gy * 7 + 3);
        idle(3);
    endtask

    task automatic sweep(input string name, input bit stall_test);
        int cnt;
        int guard;
        cnt   = 0;
        guard = 0;
        while (busy === 1'b1 && guard < 200) begin
            cnt++;
            guard++;
            check({name, "_wr_ready_low"}, {31'd0, wr_ready}, 32'd0);
            if (stall_test) begin
                clear_req = (cnt == 3);
                wr_valid  = (cnt >= 5 && cnt <= 8);
                wr_addr   = 4'd0;
                wr_data   = 8'd65;
            end
            @(negedge clk);
        end
        wr_valid  = 1'b0;
        clear_req = 1'b0;
        check({name, "_busy_cycles"}, cnt, 32'd10);
        for (int i = 0; i < CELLS; i++) cells[i] = 8'd32;
    endtask

    task automatic frames(input int n);
        issue      = 1'b0;
        hc_visible = 11'd0;
        vc_visible = 11'd0;
        repeat (n) @(negedge clk);
        frame_cnt += n;
        hc_visible = 11'd1000;
        vc_visible = 11'd1000;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < CELLS; i++) cells[i] = 8'd32;

        repeat (3) @(negedge clk);
        check("rst_busy",         {31'd0, busy},         32'd1);
        check("rst_wr_ready",     {31'd0, wr_ready},     32'd0);
        check("rst_in_square",    {31'd0, in_square},    32'd0);
        check("rst_in_character", {31'd0, in_character}, 32'd0);

        rst = 1'b1;
        sweep("init", 1'b0);
        check("post_init_wr_ready", {31'd0, wr_ready}, 32'd1);
        check("post_init_busy",     {31'd0, busy},     32'd0);

        for (int i = 0; i < CELLS; i++) wr(i, 8'd65, 1'b1);
        scan_cell(0);
        scan_cell(9);

        // Reset mid-operation, then again part-way into the sweep it starts.
        rst = 1'b0;
        #1;
        check("mid_rst_busy",      {31'd0, busy},      32'd1);
        check("mid_rst_wr_ready",  {31'd0, wr_ready},  32'd0);
        check("mid_rst_in_square", {31'd0, in_square}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        sweep("restart", 1'b0);
        scan_cell(0);
        scan_cell(4);
        scan_cell(9);

        wr(0, 8'd65, 1'b1);
        for (int v = 457; v <= 512; v++)
            for (int h = 37; h <= 78; h++)
                pix(h, v);
        idle(3);

        pix(29, 460);
        pix(30, 460);
        pix(246, 460);
        pix(247, 460);
        for (int h = 30; h <= 36; h++) pix(h, 460);
        pix(100, 449);
        pix(100, 450);
        pix(100, 568);
        pix(100, 569);
        idle(3);

        wr(10, 8'd66, 1'b1);
        wr(1, 8'd66, 1'b1);
        wr(5, 8'd65, 1'b1);
        wr(6, 8'd66, 1'b1);
        wr(9, 8'd66, 1'b1);
        scan_cell(0);
        scan_cell(1);
        scan_cell(2);
        scan_cell(5);
        scan_cell(6);
        scan_cell(9);

        // Clear with a simultaneous write, a second clear 3 cycles in, stalled writes.
        clear_req = 1'b1;
        wr_valid  = 1'b1;
        wr_addr   = 4'd3;
        wr_data   = 8'd66;
        check("clear_cycle_wr_ready", {31'd0, wr_ready}, 32'd1);
        @(negedge clk);
        clear_req = 1'b0;
        wr_valid  = 1'b0;
        sweep("clear", 1'b1);
        check("post_clear_wr_ready", {31'd0, wr_ready}, 32'd1);
        scan_cell(0);
        scan_cell(1);
        scan_cell(3);
        scan_cell(5);
        scan_cell(6);
        scan_cell(9);

`ifdef TEXT_CURSOR_EN
        wr(5, 8'd66, 1'b1);
        wr(6, 8'd65, 1'b1);
        frames(16);
        scan_cell(6);
        scan_cell(5);
        frames(16);
        scan_cell(6);
`endif

        idle(4);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
